prescaled_counter: RTL and testbench

Parametrised successor to the team's 8-bit enable/reset counter. It adds configurable width, a programmable prescaler, up/down direction, auto-reload or one-shot mode, synchronous load, a terminal-count pulse and a compare-match pulse. It is the timer primitive for core-side peripherals and testbench stimulus, and is driven by the single core clock.

---
 rtl/prescaled_counter.sv | 152 +++++++++++++++
 tb/tb_prescaled_counter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/prescaled_counter.sv
// prescaled_counter
//   Parametrised timer primitive: WIDTH-bit up/down counter advanced by a
//   programmable prescaler, with auto-reload or one-shot behaviour, a
//   synchronous load, a terminal-count pulse and a compare-match pulse.
//
// Ports
//   clk        core clock, all state updates on the rising edge
//   reset      synchronous, active-high, highest priority
//   enable     count enable (IDLE->RUN when high, back to IDLE when low)
//   dir        0 = count up, 1 = count down
//   mode       0 = auto-reload, 1 = one-shot (halt on terminal tick)
//   load       synchronous load strobe, beats a tick on the same edge
//   load_val   value written to out on load
//   period     terminal value when counting up / reload value when down
//   prescale   one tick every prescale+1 cycles while running
//   compare    value that raises cmp_match when reached by a normal tick
//   out        counter value
//   tc         one-cycle pulse after a terminal tick
//   cmp_match  one-cycle pulse after a non-terminal tick landing on compare
//   running    state is RUN
//   done       state is HALT
module prescaled_counter #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  dir,
  input  logic                  mode,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [WIDTH-1:0]      period,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [WIDTH-1:0]      compare,
  output logic [WIDTH-1:0]      out,
  output logic                  tc,
  output logic                  cmp_match,
  output logic                  running,
  output logic                  done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      out_q, out_d;
  logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic                  tc_q, tc_d;
  logic                  cmp_match_q, cmp_match_d;
  logic                  running_q, running_d;
  logic                  done_q, done_d;

  logic                  counting;
  logic                  pre_hit;
  logic                  terminal;
  logic                  tick;
  logic [WIDTH-1:0]      next_val;

  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    pre_cnt_d   = pre_cnt_q;
    tc_d        = 1'b0;
    cmp_match_d = 1'b0;
    tick        = 1'b0;
    terminal    = 1'b0;
    next_val    = out_q;

    // The prescaler only advances on edges where we stay in RUN; the edge
    // that drops enable leaves pre_cnt untouched so a resumed run picks up
    // the partial prescale period.
    counting = (state_q == ST_RUN) && enable;
    pre_hit  = (pre_cnt_q == prescale);

    // Candidate value for a tick on this edge.
    if (!dir) begin
      terminal = (out_q >= period);
      if (terminal) next_val = mode ? out_q : '0;
      else          next_val = out_q + WIDTH'(1);
    end else begin
      terminal = (out_q == '0);
      if (terminal) next_val = mode ? out_q : period;
      else          next_val = out_q - WIDTH'(1);
    end

    if (load) begin
      out_d     = load_val;
      pre_cnt_d = '0;
    end else if (counting) begin
      if (pre_hit) begin
        tick        = 1'b1;
        pre_cnt_d   = '0;
        out_d       = next_val;
        tc_d        = terminal;
        // Reload/wrap values are never reported as compare hits.
        cmp_match_d = !terminal && (next_val == compare);
      end else begin
        pre_cnt_d = pre_cnt_q + PRESCALE_W'(1);
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!enable)                  state_d = ST_IDLE;
        else if (tick && terminal && mode) state_d = ST_HALT;
      end
      ST_HALT: begin
        if (!enable)   state_d = ST_IDLE;
        else if (load) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase

    // Status flags are decoded from the next state so they are flops too.
    running_d = (state_d == ST_RUN);
    done_d    = (state_d == ST_HALT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      out_q       <= '0;
      pre_cnt_q   <= '0;
      tc_q        <= 1'b0;
      cmp_match_q <= 1'b0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      pre_cnt_q   <= pre_cnt_d;
      tc_q        <= tc_d;
      cmp_match_q <= cmp_match_d;
      running_q   <= running_d;
      done_q      <= done_d;
    end
  end

  assign out       = out_q;
  assign tc        = tc_q;
  assign cmp_match = cmp_match_q;
  assign running   = running_q;
  assign done      = done_q;

endmodule

// File: tb/tb_prescaled_counter.sv
// Self-checking bench for prescaled_counter (WIDTH=8, PRESCALE_W=8).
// A behavioural model predicts every output after every edge; directed
// scenarios from the timer's intended use are followed by random traffic.
module tb_prescaled_counter;

  logic       clk = 1'b0;
  logic       reset, enable, dir, mode, load;
  logic [7:0] load_val, period, prescale, compare;
  logic [7:0] out;
  logic       tc, cmp_match, running, done;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state
  int m_out, m_pre;
  bit m_tc, m_cmp, m_run, m_halt;

  always #5 clk = ~clk;

  prescaled_counter #(.WIDTH(8), .PRESCALE_W(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .dir(dir), .mode(mode),
    .load(load), .load_val(load_val), .period(period), .prescale(prescale),
    .compare(compare), .out(out), .tc(tc), .cmp_match(cmp_match),
    .running(running), .done(done)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // Predict the effect of the coming edge from the current inputs.
  task automatic model_edge();
    bit term_tick;
    term_tick = 1'b0;
    if (reset) begin
      m_out = 0; m_pre = 0; m_tc = 0; m_cmp = 0; m_run = 0; m_halt = 0;
      return;
    end
    m_tc  = 0;
    m_cmp = 0;
    if (load) begin
      m_out = load_val;
      m_pre = 0;
    end else if (m_run && enable) begin
      if (m_pre == int'(prescale)) begin
        m_pre = 0;
        if (dir == 1'b0) begin
          if (m_out >= int'(period)) begin
            term_tick = 1; m_tc = 1;
            if (!mode) m_out = 0;
          end else begin
            m_out = (m_out + 1) % 256;
            m_cmp = (m_out == int'(compare));
          end
        end else begin
          if (m_out == 0) begin
            term_tick = 1; m_tc = 1;
            if (!mode) m_out = period;
          end else begin
            m_out = m_out - 1;
            m_cmp = (m_out == int'(compare));
          end
        end
      end else begin
        m_pre = m_pre + 1;
      end
    end
    // Mode transitions
    if (!enable) begin
      m_run = 0; m_halt = 0;
    end else if (!m_run && !m_halt) begin
      m_run = 1;
    end else if (m_run && term_tick && mode) begin
      m_run = 0; m_halt = 1;
    end else if (m_halt && load) begin
      m_run = 1; m_halt = 0;
    end
  endtask

  // One clock: predict, clock, compare all outputs 1 ns after the edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      model_edge();
      @(posedge clk);
      #1;
      check("out",       int'(out),       m_out);
      check("tc",        int'(tc),        int'(m_tc));
      check("cmp_match", int'(cmp_match), int'(m_cmp));
      check("running",   int'(running),   int'(m_run));
      check("done",      int'(done),      int'(m_halt));
    end
  endtask

  task automatic do_reset();
    reset = 1; enable = 0; load = 0;
    step(2);
    reset = 0;
  endtask

  initial begin
    reset = 1; enable = 0; dir = 0; mode = 0; load = 0;
    load_val = 0; period = 8'd255; prescale = 0; compare = 8'd200;
    m_out = 0; m_pre = 0; m_tc = 0; m_cmp = 0; m_run = 0; m_halt = 0;

    // Reset state
    step(2);
    check("reset_out", int'(out), 0);
    check("reset_running", int'(running), 0);
    reset = 0;

    // Up count full wrap, prescale 0
    $display("[TB] scenario: up wrap 0..255");
    enable = 1;
    step(260);

    // Prescale 3 with an enable gap mid-period
    $display("[TB] scenario: prescale 3 with pause");
    do_reset();
    prescale = 8'd3; enable = 1;
    step(10);
    enable = 0;
    step(2);
    enable = 1;
    step(14);

    // Down count with reload
    $display("[TB] scenario: down period 9 from load 5");
    do_reset();
    prescale = 0; dir = 1; period = 8'd9; enable = 1;
    load = 1; load_val = 8'd5;
    step(1);
    load = 0;
    step(12);

    // One-shot up then reload from HALT
    $display("[TB] scenario: one-shot period 4");
    do_reset();
    dir = 0; mode = 1; period = 8'd4; enable = 1;
    step(8);
    check("oneshot_done", int'(done), 1);
    load = 1; load_val = 8'd0;
    step(1);
    load = 0;
    step(6);

    // Compare match, and a load of the compare value
    $display("[TB] scenario: compare 7");
    do_reset();
    mode = 0; period = 8'd20; compare = 8'd7; enable = 1;
    step(10);
    load = 1; load_val = 8'd7;
    step(1);
    load = 0;
    step(2);

    // Reset mid-run with enable held
    $display("[TB] scenario: reset while running at 0x37");
    do_reset();
    period = 8'd255; enable = 1;
    step(1);
    load = 1; load_val = 8'h37;
    step(1);
    load = 0;
    step(1);
    reset = 1;
    step(1);
    check("midreset_out", int'(out), 0);
    reset = 0;
    step(3);

    // Random traffic
    $display("[TB] scenario: random");
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 199) == 0);
      enable   = ($urandom_range(0, 9) != 0);
      load     = ($urandom_range(0, 24) == 0);
      load_val = 8'($urandom);
      if ($urandom_range(0, 29) == 0) begin
        dir      = 1'($urandom);
        mode     = ($urandom_range(0, 3) == 0);
        period   = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 12)) : 8'($urandom);
        prescale = 8'($urandom_range(0, 3));
        compare  = 8'($urandom_range(0, 12));
      end
      step(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
